decode_seq: RTL and testbench
=============================

DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 Parameter PE_W, default 2: width of the destination-PE field.
REQ-002 Parameter ADDR_W, default 3: width of the register start-address field.
REQ-003 Parameter LEN_W, default 3: width of the data-length field.
REQ-004 Parameter CNT_W, default 8: width of the drop counter.
REQ-005 Derived constant INST_W = PE_W+ADDR_W+LEN_W: instruction width, 8 at defaults.
REQ-006 Port clock  in  1: single clock; all logic is on its rising edge.
REQ-007 Port reset  in  1: synchronous, active-high reset.
REQ-008 Port io_din_input_valid  in  1: an instruction is offered.
REQ-009 Port io_din_input_ready  out  1: the block accepts the offered instruction.
REQ-010 Port io_din_input_bits  in  INST_W: instruction word; [PE_W-1:0] dest PE, next ADDR_W bits start address, top LEN_W bits length.
REQ-011 Port io_dout_valid  out  1: a send beat is presented.
REQ-012 Port io_dout_ready  in  1: the downstream consumer accepts the beat.
REQ-013 Port io_dout_dest_pe  out  PE_W: destination PE of the beat.
REQ-014 Port io_dout_reg_addr  out  ADDR_W: register address of the beat.
REQ-015 Port io_dout_last  out  1: marks the final beat of the instruction.
REQ-016 Port io_drop_cnt  out  CNT_W: count of zero-length instructions.

Function
REQ-017 An input handshake occurs on a cycle with input_valid=1 and input_ready=1; an output handshake occurs on a cycle with dout_valid=1 and dout_ready=1.
REQ-018 The FSM SHALL have two states: IDLE and SEND.
REQ-019 In IDLE, input_ready SHALL be 1 and dout_valid SHALL be 0.
REQ-020 On an input handshake with length L>0, the block SHALL latch pe, addr and L, and enter SEND on the next cycle.
REQ-021 An accepted instruction SHALL therefore produce its first beat one cycle after acceptance.
REQ-022 On an input handshake with L=0, the block SHALL emit no beats, SHALL stay in (or return to) IDLE, and SHALL increment drop_cnt.
REQ-023 drop_cnt SHALL saturate at all-ones and SHALL not wrap.
REQ-024 In SEND, dout_valid SHALL be 1.
REQ-025 In SEND, dest_pe SHALL equal the latched pe.
REQ-026 In SEND, reg_addr SHALL equal the current address.
REQ-027 In SEND, dout_last SHALL be 1 exactly when the remaining count is 1.
REQ-028 Each output handshake SHALL advance the address by 1, modulo 2^ADDR_W (wrap-around), and SHALL decrement the remaining count.
REQ-029 An instruction of length L SHALL produce exactly L beats with consecutive wrapped addresses starting at the latched address.
REQ-030 While dout_ready=0, all dout outputs SHALL hold stable and the state SHALL not advance.
REQ-031 In SEND, input_ready SHALL be 1 only in the cycle of an output handshake on the last beat (a combinational path from dout_ready to input_ready), giving back-to-back bursts with no bubble.
REQ-032 On a simultaneous last-beat handshake and input handshake with L>0, the new instruction SHALL load and SEND SHALL continue; with L=0, drop_cnt SHALL increment and the FSM SHALL go to IDLE.
REQ-033 Outputs SHALL not depend combinationally on input_bits.

Reset
REQ-034 While reset is high, the FSM SHALL be in IDLE, dout_valid, dout_last and drop_cnt SHALL be 0, and the address and remaining-count registers SHALL be 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst with no further beats, and any instruction offered during reset SHALL be ignored.

Structure
REQ-036 The field-offset constants, the FSM state enum and the instruction-field struct SHALL be defined in the shared package decode_pkg.
REQ-037 Field extraction SHALL be a sub-module inst_fields, a pure combinational split of the instruction word into pe, addr and len.

Verification (defaults)
REQ-038 Offer 0xA7 with dout_ready=1 -> 5 beats, pe=3, addrs 1,2,3,4,5, last on addr 5, then IDLE.
REQ-039 Offer 0x79 -> 3 beats, pe=1, addrs 6,7,0 (wrap), last on addr 0.
REQ-040 Offer 0x1E -> no beats, and drop_cnt goes 0->1.
REQ-041 Offer 0x27 then 0x4A held valid -> beats (pe3,a1,last), (pe2,a2), (pe2,a3,last) on consecutive cycles, with no gap.
REQ-042 Offer 0xA7 and drop dout_ready for 3 cycles at the 2nd beat -> the beat holds at addr 2, and the sequence completes intact.
REQ-043 Assert reset on the 3rd beat of 0xA7 -> dout_valid=0 next cycle, drop_cnt=0, and 0x79 accepted afterwards behaves per REQ-039.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and field-offset helpers for the instruction decode/sequencer.
// Instruction layout, LSB first: dest PE, register start address, length.
package decode_pkg;

  localparam int DEF_PE_W    = 2;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_LEN_W   = 3;
  localparam int FIELD_MAX_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Fields are zero-extended to a common width so one struct serves every parameterisation.
  typedef struct packed {
    logic [FIELD_MAX_W-1:0] len;
    logic [FIELD_MAX_W-1:0] addr;
    logic [FIELD_MAX_W-1:0] pe;
  } inst_fields_t;

  function automatic int pe_lsb();
    return 0;
  endfunction

  function automatic int addr_lsb(input int pe_w);
    return pe_w;
  endfunction

  function automatic int len_lsb(input int pe_w, input int addr_w);
    return pe_w + addr_w;
  endfunction

endpackage

// File: rtl/inst_fields.sv
// Pure combinational split of an instruction word into pe, addr and len.
module inst_fields
  import decode_pkg::*;
#(
  parameter int PE_W   = DEF_PE_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic [PE_W+ADDR_W+LEN_W-1:0] bits,
  output inst_fields_t                 fields
);

  localparam int PE_LSB   = pe_lsb();
  localparam int ADDR_LSB = addr_lsb(PE_W);
  localparam int LEN_LSB  = len_lsb(PE_W, ADDR_W);

  always_comb begin
    fields                   = '0;
    fields.pe[PE_W-1:0]      = bits[PE_LSB +: PE_W];
    fields.addr[ADDR_W-1:0]  = bits[ADDR_LSB +: ADDR_W];
    fields.len[LEN_W-1:0]    = bits[LEN_LSB +: LEN_W];
  end

endmodule

// File: rtl/decode_seq.sv
// Decodes {len, addr, pe} instructions into len beats at consecutive wrapped
// addresses; zero-length instructions are dropped and counted (saturating).
module decode_seq
  import decode_pkg::*;
#(
  parameter int PE_W   = 2,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 8,
  localparam int INST_W = PE_W + ADDR_W + LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_din_input_valid,
  output logic              io_din_input_ready,
  input  logic [INST_W-1:0] io_din_input_bits,
  output logic              io_dout_valid,
  input  logic              io_dout_ready,
  output logic [PE_W-1:0]   io_dout_dest_pe,
  output logic [ADDR_W-1:0] io_dout_reg_addr,
  output logic              io_dout_last,
  output logic [CNT_W-1:0]  io_drop_cnt
);

  // Handshakes: a beat/instruction transfers on a rising edge where valid and
  // ready are both 1; valid never waits on ready, ready may depend on valid's peer.

  inst_fields_t fields;
  logic [PE_W-1:0]   in_pe;
  logic [ADDR_W-1:0] in_addr;
  logic [LEN_W-1:0]  in_len;
  logic              unused_field_bits;

  inst_fields #(.PE_W(PE_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_fields (
    .bits   (io_din_input_bits),
    .fields (fields)
  );

  assign in_pe   = fields.pe[PE_W-1:0];
  assign in_addr = fields.addr[ADDR_W-1:0];
  assign in_len  = fields.len[LEN_W-1:0];
  assign unused_field_bits = ^{fields.pe[FIELD_MAX_W-1:PE_W],
                               fields.addr[FIELD_MAX_W-1:ADDR_W],
                               fields.len[FIELD_MAX_W-1:LEN_W]};

  state_t            state_q, state_d;
  logic [PE_W-1:0]   pe_q, pe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              last_beat, out_hs, in_hs;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pe_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pe_q    <= pe_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pe_d      = pe_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    drop_d    = drop_q;
    last_beat = (state_q == SEND) && (rem_q == LEN_W'(1));
    out_hs    = (state_q == SEND) && io_dout_ready;
    // Accepting on the last-beat handshake lets the next burst follow with no bubble.
    io_din_input_ready = (state_q == IDLE) || (out_hs && last_beat);
    in_hs     = io_din_input_valid && io_din_input_ready;

    if (out_hs) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - LEN_W'(1);
      if (last_beat) state_d = IDLE;
    end

    if (in_hs) begin
      if (in_len != '0) begin
        pe_d    = in_pe;
        addr_d  = in_addr;
        rem_d   = in_len;
        state_d = SEND;
      end else begin
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        state_d = IDLE;
      end
    end
  end

  assign io_dout_valid    = (state_q == SEND);
  assign io_dout_dest_pe  = pe_q;
  assign io_dout_reg_addr = addr_q;
  assign io_dout_last     = last_beat;
  assign io_drop_cnt      = drop_q;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed scenarios plus random traffic, checked against
// a beat-queue reference model built from the instruction-level behaviour.
module tb_decode_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] din_bits = '0;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [1:0] dout_pe;
  logic [2:0] dout_addr;
  logic       dout_last;
  logic [7:0] drop_cnt;

  decode_seq dut (
    .clock              (clock),
    .reset              (reset),
    .io_din_input_valid (din_valid),
    .io_din_input_ready (din_ready),
    .io_din_input_bits  (din_bits),
    .io_dout_valid      (dout_valid),
    .io_dout_ready      (dout_ready),
    .io_dout_dest_pe    (dout_pe),
    .io_dout_reg_addr   (dout_addr),
    .io_dout_last       (dout_last),
    .io_drop_cnt        (drop_cnt)
  );

  always #5 clock = ~clock;

  // Beat encoding {pe, addr, last}
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  int         obs_cyc[$];
  int         drop_exp = 0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic accept(input logic [7:0] b);
    int         len;
    logic [2:0] a;
    len = int'(b[7:5]);
    if (len == 0) begin
      if (drop_exp < 255) drop_exp++;
    end else begin
      for (int i = 0; i < len; i++) begin
        a = b[4:2] + 3'(i);
        exp_q.push_back({b[1:0], a, (i == len - 1) ? 1'b1 : 1'b0});
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic r);
    logic       exp_ready;
    logic       exp_hs;
    logic [5:0] got;
    @(negedge clock);
    din_valid  = v;
    din_bits   = b;
    dout_ready = r;
    #1;
    cyc++;
    got = {dout_pe, dout_addr, dout_last};
    n_vec++;
    if (dout_valid !== (exp_q.size() != 0)) begin
      n_err++;
      $display("FAIL dout_valid cyc %0d: got %b expected %b", cyc, dout_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      if (got !== exp_q[0]) begin
        n_err++;
        $display("FAIL beat cyc %0d: got pe=%0d addr=%0d last=%b expected pe=%0d addr=%0d last=%b",
                 cyc, got[5:4], got[3:1], got[0], exp_q[0][5:4], exp_q[0][3:1], exp_q[0][0]);
      end
    end
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
    n_vec++;
    if (din_ready !== exp_ready) begin
      n_err++;
      $display("FAIL input_ready cyc %0d: got %b expected %b", cyc, din_ready, exp_ready);
    end
    n_vec++;
    if (drop_cnt !== 8'(drop_exp)) begin
      n_err++;
      $display("FAIL drop_cnt cyc %0d: got %0d expected %0d", cyc, drop_cnt, drop_exp);
    end
    if (dout_valid === 1'b1 && r) begin
      obs_q.push_back(got);
      obs_cyc.push_back(cyc);
    end
    exp_hs = (exp_q.size() != 0) && r;
    if (exp_hs) void'(exp_q.pop_front());
    if (v && exp_ready) accept(b);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain timeout: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic check_addrs(input string name, input logic [1:0] pe,
                             input logic [2:0] first, input int len);
    logic [2:0] a;
    n_vec++;
    if (obs_q.size() != len) begin
      n_err++;
      $display("FAIL %s beat count: got %0d expected %0d", name, obs_q.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        a = first + 3'(i);
        n_vec++;
        if (obs_q[i] !== {pe, a, (i == len - 1) ? 1'b1 : 1'b0}) begin
          n_err++;
          $display("FAIL %s beat %0d: got %h expected %h", name, i, obs_q[i],
                   {pe, a, (i == len - 1) ? 1'b1 : 1'b0});
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      din_valid = 1'b1; din_bits = 8'h27; dout_ready = 1'b1;
      #1;
      n_vec++;
      if ({dout_valid, dout_last, drop_cnt, din_ready} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
        n_err++;
        $display("FAIL reset state: got valid=%b last=%b drop=%0d ready=%b expected 0 0 0 1",
                 dout_valid, dout_last, drop_cnt, din_ready);
      end
    end
    @(negedge clock);
    reset = 1'b0; din_valid = 1'b0;
    exp_q.delete(); drop_exp = 0;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_burst();
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'hA7, 1'b1);
    drain();
    check_addrs("burst_a7", 2'd3, 3'd1, 5);
  endtask

  task automatic test_wrap();
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'h79, 1'b1);
    drain();
    check_addrs("wrap_79", 2'd1, 3'd6, 3);
  endtask

  task automatic test_drop();
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'h1E, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_vec++;
    if (obs_q.size() != 0 || drop_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL drop_1e: got beats=%0d drop=%0d expected beats=0 drop=1", obs_q.size(), drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'h27, 1'b1);
    step(1'b1, 8'h4A, 1'b1);
    drain();
    n_vec++;
    if (obs_q.size() != 3) begin
      n_err++;
      $display("FAIL b2b count: got %0d expected 3", obs_q.size());
    end else begin
      n_vec++;
      if ({obs_q[0], obs_q[1], obs_q[2]} !== {6'b11_001_1, 6'b10_010_0, 6'b10_011_1}) begin
        n_err++;
        $display("FAIL b2b beats: got %h %h %h expected 33 24 27", obs_q[0], obs_q[1], obs_q[2]);
      end
      n_vec++;
      if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
        n_err++;
        $display("FAIL b2b gap: got cycles %0d %0d %0d expected consecutive",
                 obs_cyc[0], obs_cyc[1], obs_cyc[2]);
      end
    end
  endtask

  task automatic test_stall();
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'hA7, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h27, 1'b0);
      n_vec++;
      if ({dout_valid, dout_addr, dout_last} !== {1'b1, 3'd2, 1'b0}) begin
        n_err++;
        $display("FAIL stall hold: got valid=%b addr=%0d last=%b expected 1 2 0",
                 dout_valid, dout_addr, dout_last);
      end
    end
    drain();
    check_addrs("stall_a7", 2'd3, 3'd1, 5);
  endtask

  task automatic test_reset_mid();
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'hA7, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clock);
    reset = 1'b1; din_valid = 1'b1; din_bits = 8'h79; dout_ready = 1'b1;
    @(negedge clock);
    #1;
    n_vec++;
    if ({dout_valid, dout_last, drop_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset mid-burst: got valid=%b last=%b drop=%0d expected 0 0 0",
               dout_valid, dout_last, drop_cnt);
    end
    reset = 1'b0; din_valid = 1'b0;
    exp_q.delete(); drop_exp = 0;
    step(1'b0, 8'h00, 1'b1);
    obs_q.delete(); obs_cyc.delete();
    step(1'b1, 8'h79, 1'b1);
    drain();
    check_addrs("after_reset_79", 2'd1, 3'd6, 3);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), b, ($urandom_range(0, 3) != 0));
    end
    drain();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) step(1'b1, {3'b000, 5'($urandom_range(0, 31))}, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_vec++;
    if (drop_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL drop saturate: got %0d expected 255", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_wrap();
    test_drop();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
